// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: opcode encodings and status-word layout.
package alu_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_ADD     = 3'b011;
  localparam logic [2:0] OP_SUB     = 3'b100;
  localparam logic [2:0] OP_SHL     = 3'b101;
  localparam logic [2:0] OP_SHR     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam int STATUS_W = 4;
  localparam int ST_Z     = 0;
  localparam int ST_N     = 1;
  localparam int ST_C     = 2;
  localparam int ST_V     = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath producing result, {V,C,N,Z} status and an illegal-opcode flag.
// Shifts exist only when ALU_PIPE_SHIFT_EN is defined; otherwise SHL/SHR decode as illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]          opcode,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  output logic [WIDTH-1:0]    result,
  output logic [STATUS_W-1:0] status,
  output logic                err
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;

  // The extra top bit of the difference is the unsigned borrow (in0 < in1).
  assign sum  = {1'b0, in0} + {1'b0, in1};
  assign diff = {1'b0, in0} - {1'b0, in1};

`ifdef ALU_PIPE_SHIFT_EN
  localparam int SHAMT_W = $clog2(WIDTH);
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     shlFull;
  logic [WIDTH:0]     shrFull;

  // A spare guard bit catches the last bit shifted out; it is naturally 0 for amount 0.
  assign shamt   = in1[SHAMT_W-1:0];
  assign shlFull = {1'b0, in0} << shamt;
  assign shrFull = {in0, 1'b0} >> shamt;
`endif

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (opcode)
      OP_AND: result = in0 & in1;
      OP_OR:  result = in0 | in1;
      OP_XOR: result = in0 ^ in1;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]);
      end
`ifdef ALU_PIPE_SHIFT_EN
      OP_SHL: begin
        result = shlFull[WIDTH-1:0];
        carry  = shlFull[WIDTH];
      end
      OP_SHR: begin
        result = shrFull[WIDTH:1];
        carry  = shrFull[0];
      end
`endif
      default: err = 1'b1;
    endcase

    status = '0;
    if (!err) begin
      status[ST_Z] = (result == '0);
      status[ST_N] = result[WIDTH-1];
      status[ST_C] = carry;
      status[ST_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline (operand register, result register) with a
// saturating illegal-opcode counter. Optional shifts: define ALU_PIPE_SHIFT_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          opcode,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic [STATUS_W-1:0] status,
  output logic                out_err,
  output logic [CNT_W-1:0]    err_count
);

  logic                s1_valid_q;
  logic [2:0]          s1_opcode_q;
  logic [WIDTH-1:0]    s1_in0_q;
  logic [WIDTH-1:0]    s1_in1_q;
  logic                s2_valid_q;
  logic [WIDTH-1:0]    out_q;
  logic [STATUS_W-1:0] status_q;
  logic                err_q;
  logic [CNT_W-1:0]    err_count_q;
  logic [CNT_W-1:0]    err_count_d;

  logic                s1_adv;
  logic                s2_adv;
  logic [WIDTH-1:0]    core_result;
  logic [STATUS_W-1:0] core_status;
  logic                core_err;

  // Each stage moves when its successor has room or is draining this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opcode (s1_opcode_q),
    .in0    (s1_in0_q),
    .in1    (s1_in1_q),
    .result (core_result),
    .status (core_status),
    .err    (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_in0_q    <= '0;
      s1_in1_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_opcode_q <= opcode;
        s1_in0_q    <= in0;
        s1_in1_q    <= in1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q    <= core_result;
        status_q <= core_status;
        err_q    <= core_err;
      end
    end
  end

  // Errors are counted as they retire, so flushed ops never reach the count.
  always_comb begin
    err_count_d = err_count_q;
    if (s2_valid_q && out_ready && err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign status    = status_q;
  assign out_err   = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16, CNT_W=8); shift expectations
// follow ALU_PIPE_SHIFT_EN.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [2:0]  opcode;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        outValid;
  logic        outReady;
  logic [15:0] dutOut;
  logic [3:0]  dutStatus;
  logic        outErr;
  logic [7:0]  errCount;

  int testCount = 0;
  int failCount = 0;

  alu_pipe #(
    .WIDTH (16),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .opcode    (opcode),
    .in0       (in0),
    .in1       (in1),
    .out_valid (outValid),
    .out_ready (outReady),
    .out       (dutOut),
    .status    (dutStatus),
    .out_err   (outErr),
    .err_count (errCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    inValid = 1'b1;
    opcode  = op;
    in0     = a;
    in1     = b;
    tick();
    inValid = 1'b0;
  endtask

  // Single op through an otherwise idle pipeline with out_ready high.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] expOut,
                       input logic [3:0] expSt, input logic expErr);
    checkOutput({tag, "_inready"}, 32'(inReady), 32'(1'b1));
    applyStimulus(op, a, b);
    checkOutput({tag, "_early"}, 32'(outValid), 32'(1'b0));
    tick();
    checkOutput({tag, "_valid"}, 32'(outValid), 32'(1'b1));
    checkOutput({tag, "_out"}, 32'(dutOut), 32'(expOut));
    checkOutput({tag, "_status"}, 32'(dutStatus), 32'(expSt));
    checkOutput({tag, "_err"}, 32'(outErr), 32'(expErr));
    tick();
  endtask

  initial begin
    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    opcode   = 3'b000;
    in0      = '0;
    in1      = '0;
    repeat (2) tick();
    rstN = 1'b1;
    tick();

    checkOutput("rst_inready", 32'(inReady), 32'(1'b1));
    checkOutput("rst_outvalid", 32'(outValid), 32'(1'b0));
    checkOutput("rst_out", 32'(dutOut), 32'(16'h0000));
    checkOutput("rst_status", 32'(dutStatus), 32'(4'h0));
    checkOutput("rst_err", 32'(outErr), 32'(1'b0));
    checkOutput("rst_count", 32'(errCount), 32'(8'd0));

    // status = {V,C,N,Z}
    runOp("add_carry", 3'b011, 16'hFFFF, 16'h0002, 16'h0001, 4'b0100, 1'b0);
    runOp("sub_borrow", 3'b100, 16'h0000, 16'h0002, 16'hFFFE, 4'b0110, 1'b0);
    runOp("sub_zero", 3'b100, 16'h0005, 16'h0005, 16'h0000, 4'b0001, 1'b0);
    runOp("add_ovf", 3'b011, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1'b0);
    runOp("and", 3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0);
    runOp("or_neg", 3'b001, 16'h8000, 16'h0001, 16'h8001, 4'b0010, 1'b0);
    runOp("xor_zero", 3'b010, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 1'b0);
    runOp("sub_sovf", 3'b100, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1'b0);

    // Backpressure: A=1+1, B=2+2, C=3+3, D=4+4 offered back-to-back, consumer stalled.
    outReady = 1'b0;
    inValid  = 1'b1;
    opcode   = 3'b011;
    in0 = 16'd1; in1 = 16'd1;
    tick();
    checkOutput("bp_ready1", 32'(inReady), 32'(1'b1));
    in0 = 16'd2; in1 = 16'd2;
    tick();
    checkOutput("bp_ready2", 32'(inReady), 32'(1'b0));
    in0 = 16'd3; in1 = 16'd3;
    tick();
    checkOutput("bp_ready3", 32'(inReady), 32'(1'b0));
    checkOutput("bp_hold_valid", 32'(outValid), 32'(1'b1));
    checkOutput("bp_hold_out", 32'(dutOut), 32'(16'd2));
    outReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(inReady), 32'(1'b1));
    tick();
    checkOutput("bp_outB", 32'(dutOut), 32'(16'd4));
    in0 = 16'd4; in1 = 16'd4;
    tick();
    inValid = 1'b0;
    checkOutput("bp_outC", 32'(dutOut), 32'(16'd6));
    checkOutput("bp_validC", 32'(outValid), 32'(1'b1));
    tick();
    checkOutput("bp_outD", 32'(dutOut), 32'(16'd8));
    checkOutput("bp_validD", 32'(outValid), 32'(1'b1));
    tick();
    checkOutput("bp_drained", 32'(outValid), 32'(1'b0));

    // Illegal opcode: counted only when it retires.
    applyStimulus(3'b111, 16'd5, 16'd5);
    tick();
    checkOutput("ill_out", 32'(dutOut), 32'(16'h0000));
    checkOutput("ill_status", 32'(dutStatus), 32'(4'h0));
    checkOutput("ill_err", 32'(outErr), 32'(1'b1));
    checkOutput("ill_count_before", 32'(errCount), 32'(8'd0));
    tick();
    checkOutput("ill_count_after", 32'(errCount), 32'(8'd1));

    inValid = 1'b1;
    opcode  = 3'b111;
    repeat (300) tick();
    inValid = 1'b0;
    repeat (3) tick();
    checkOutput("ill_saturate", 32'(errCount), 32'(8'd255));

`ifdef ALU_PIPE_SHIFT_EN
    runOp("shl", 3'b101, 16'h8001, 16'd1, 16'h0002, 4'b0100, 1'b0);
    runOp("shr", 3'b110, 16'h0003, 16'd17, 16'h0001, 4'b0100, 1'b0);
    runOp("shl_zero_amt", 3'b101, 16'h8001, 16'd16, 16'h8001, 4'b0010, 1'b0);
`else
    runOp("shl", 3'b101, 16'h8001, 16'd1, 16'h0000, 4'b0000, 1'b1);
    runOp("shr", 3'b110, 16'h0003, 16'd17, 16'h0000, 4'b0000, 1'b1);
`endif
    checkOutput("count_held", 32'(errCount), 32'(8'd255));

    // Reset with two illegal ops in flight.
    outReady = 1'b0;
    inValid  = 1'b1;
    opcode   = 3'b111;
    tick();
    tick();
    inValid = 1'b0;
    checkOutput("rst_full_ready", 32'(inReady), 32'(1'b0));
    checkOutput("rst_full_valid", 32'(outValid), 32'(1'b1));
    rstN = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(outValid), 32'(1'b0));
    checkOutput("rst_async_count", 32'(errCount), 32'(8'd0));
    #3;
    rstN     = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_no_stale", 32'(outValid), 32'(1'b0));
    end
    checkOutput("rst_count_after", 32'(errCount), 32'(8'd0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
